// File: rtl/arp_cache_query_arb_if.sv
// rtl/arp_cache_query_arb_if.sv - requester, response and cache query signal bundle for the ARP query arbiter
interface arp_cache_query_arb_if #(
   parameter int PORTS = 2
);
   logic [PORTS-1:0]    s_req_valid;
   logic [PORTS-1:0]    s_req_ready;
   logic [PORTS*32-1:0] s_req_ip;
   logic [PORTS-1:0]    s_resp_valid;
   logic [PORTS-1:0]    s_resp_ready;
   logic                s_resp_error;
   logic [47:0]         s_resp_mac;
   logic                m_query_request_valid;
   logic                m_query_request_ready;
   logic [31:0]         m_query_request_ip;
   logic                m_query_response_valid;
   logic                m_query_response_ready;
   logic                m_query_response_error;
   logic [47:0]         m_query_response_mac;

   modport slave (
      input  s_req_valid, s_req_ip, s_resp_ready,
      input  m_query_request_ready, m_query_response_valid,
      input  m_query_response_error, m_query_response_mac,
      output s_req_ready, s_resp_valid, s_resp_error, s_resp_mac,
      output m_query_request_valid, m_query_request_ip, m_query_response_ready
   );

   modport master (
      output s_req_valid, s_req_ip, s_resp_ready,
      output m_query_request_ready, m_query_response_valid,
      output m_query_response_error, m_query_response_mac,
      input  s_req_ready, s_resp_valid, s_resp_error, s_resp_mac,
      input  m_query_request_valid, m_query_request_ip, m_query_response_ready
   );
endinterface

// File: rtl/arp_cache_query_arb.sv
// rtl/arp_cache_query_arb.sv - round-robin arbiter sharing one ARP cache query path among PORTS requesters
module arp_cache_query_arb #(
   parameter int PORTS   = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   arp_cache_query_arb_if.slave bus
);
   localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

   typedef enum logic [1:0] {IDLE, QUERY, RESP} state_t;

   state_t           state_q;
   logic [IW-1:0]    last_grant_q;
   logic [IW-1:0]    grant_q;
   logic [IW-1:0]    grant_d;
   logic             grant_found;
   logic [7:0]       cnt_q;
   logic             req_valid_q;
   logic [31:0]      req_ip_q;
   logic             resp_error_q;
   logic [47:0]      resp_mac_q;
   logic [PORTS-1:0] resp_valid_q;
   logic [PORTS-1:0] req_ready_c;
   logic             resp_take;
   logic             timeout_hit;
   int               idx;

   // Search upward from the port after the last served one, wrapping once.
   always_comb begin
      grant_d     = last_grant_q;
      grant_found = 1'b0;
      idx         = 0;
      for (int k = 1; k <= PORTS; k++) begin
         idx = (int'(last_grant_q) + k) % PORTS;
         if (!grant_found && bus.s_req_valid[IW'(idx)]) begin
            grant_d     = IW'(idx);
            grant_found = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready_c = '0;
      if (state_q == IDLE && grant_found) begin
         req_ready_c[grant_d] = 1'b1;
      end
   end

   // A cache response beats a timeout landing in the same cycle.
   assign resp_take   = (state_q == QUERY) && bus.m_query_response_valid && bus.m_query_request_ready;
   assign timeout_hit = (state_q == QUERY) && (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= IW'(PORTS - 1);
         grant_q      <= '0;
         cnt_q        <= '0;
         req_valid_q  <= 1'b0;
         req_ip_q     <= '0;
         resp_error_q <= 1'b0;
         resp_mac_q   <= '0;
         resp_valid_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_found) begin
                  grant_q     <= grant_d;
                  req_ip_q    <= bus.s_req_ip[32*int'(grant_d) +: 32];
                  cnt_q       <= '0;
                  req_valid_q <= 1'b1;
                  state_q     <= QUERY;
               end
            end
            QUERY: begin
               cnt_q <= cnt_q + 8'd1;
               if (resp_take || timeout_hit) begin
                  resp_error_q          <= resp_take ? bus.m_query_response_error : 1'b1;
                  resp_mac_q            <= resp_take ? bus.m_query_response_mac : 48'd0;
                  req_valid_q           <= 1'b0;
                  resp_valid_q          <= '0;
                  resp_valid_q[grant_q] <= 1'b1;
                  state_q               <= RESP;
               end
            end
            RESP: begin
               if (bus.s_resp_ready[grant_q]) begin
                  resp_valid_q <= '0;
                  last_grant_q <= grant_q;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.s_req_ready            = req_ready_c;
   assign bus.s_resp_valid           = resp_valid_q;
   assign bus.s_resp_error           = resp_error_q;
   assign bus.s_resp_mac             = resp_mac_q;
   assign bus.m_query_request_valid  = req_valid_q;
   assign bus.m_query_request_ip     = req_ip_q;
   assign bus.m_query_response_ready = req_valid_q;
endmodule

// File: tb/tb_arp_cache_query_arb.sv
// tb/tb_arp_cache_query_arb.sv - directed self-checking bench for arp_cache_query_arb
module tb_arp_cache_query_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   arp_cache_query_arb_if #(.PORTS(2)) bus ();

   arp_cache_query_arb #(.PORTS(2), .TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus.s_req_valid            = '0;
      bus.s_req_ip               = {32'h0B000002, 32'h0A000001};
      bus.s_resp_ready           = '0;
      bus.m_query_request_ready  = 1'b0;
      bus.m_query_response_valid = 1'b0;
      bus.m_query_response_error = 1'b0;
      bus.m_query_response_mac   = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_checks++;
      if (bus.s_resp_valid !== 2'b00 || bus.m_query_request_valid !== 1'b0 || bus.m_query_response_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_valids: got resp_valid=%b qvalid=%b qready=%b required 00/0/0",
                  bus.s_resp_valid, bus.m_query_request_valid, bus.m_query_response_ready);
      end
      n_checks++;
      if (bus.m_query_request_ip !== 32'd0 || bus.s_resp_error !== 1'b0 || bus.s_resp_mac !== 48'd0) begin
         n_errors++;
         $display("FAIL reset_data: got ip=%h err=%b mac=%h required zeros",
                  bus.m_query_request_ip, bus.s_resp_error, bus.s_resp_mac);
      end
      n_checks++;
      if (bus.s_req_ready !== 2'b00) begin
         n_errors++;
         $display("FAIL reset_ready_idle: got %b required 00", bus.s_req_ready);
      end
      bus.s_req_valid = 2'b11;
      #1;
      n_checks++;
      if (bus.s_req_ready !== 2'b01) begin
         n_errors++;
         $display("FAIL reset_priority: got %b required 01", bus.s_req_ready);
      end
      bus.s_req_valid = 2'b00;
   endtask

   task automatic test_single_query();
      apply_reset();
      bus.s_req_valid = 2'b01;
      #1;
      n_checks++;
      if (bus.s_req_ready !== 2'b01) begin
         n_errors++;
         $display("FAIL single_accept: got %b required 01", bus.s_req_ready);
      end
      @(negedge clk);
      bus.s_req_valid = 2'b00;
      n_checks++;
      if (bus.m_query_request_valid !== 1'b1 || bus.m_query_request_ip !== 32'h0A000001 || bus.m_query_response_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL single_query_out: got qvalid=%b ip=%h qready=%b required 1/0a000001/1",
                  bus.m_query_request_valid, bus.m_query_request_ip, bus.m_query_response_ready);
      end
      // Response while the request side is not ready must be dropped.
      bus.m_query_request_ready  = 1'b0;
      bus.m_query_response_valid = 1'b1;
      bus.m_query_response_mac   = 48'hDEAD_BEEF_0000;
      @(negedge clk);
      n_checks++;
      if (bus.s_resp_valid !== 2'b00) begin
         n_errors++;
         $display("FAIL single_ignore_not_ready: got %b required 00", bus.s_resp_valid);
      end
      bus.m_query_response_valid = 1'b0;
      bus.m_query_request_ready  = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.s_resp_valid !== 2'b00 || bus.m_query_request_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL single_still_query: got resp_valid=%b qvalid=%b required 00/1",
                  bus.s_resp_valid, bus.m_query_request_valid);
      end
      bus.m_query_response_valid = 1'b1;
      bus.m_query_response_error = 1'b0;
      bus.m_query_response_mac   = 48'h0200_0000_0001;
      @(negedge clk);
      bus.m_query_response_valid = 1'b0;
      n_checks++;
      if (bus.s_resp_valid !== 2'b01 || bus.s_resp_mac !== 48'h0200_0000_0001 || bus.s_resp_error !== 1'b0) begin
         n_errors++;
         $display("FAIL single_resp: got valid=%b mac=%h err=%b required 01/020000000001/0",
                  bus.s_resp_valid, bus.s_resp_mac, bus.s_resp_error);
      end
      n_checks++;
      if (bus.m_query_request_valid !== 1'b0 || bus.m_query_response_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL single_query_drop: got qvalid=%b qready=%b required 0/0",
                  bus.m_query_request_valid, bus.m_query_response_ready);
      end
      bus.s_resp_ready = 2'b01;
      @(negedge clk);
      bus.s_resp_ready = 2'b00;
      n_checks++;
      if (bus.s_resp_valid !== 2'b00) begin
         n_errors++;
         $display("FAIL single_resp_done: got %b required 00", bus.s_resp_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_port;
      logic [47:0] exp_mac;
      apply_reset();
      bus.s_req_valid           = 2'b11;
      bus.m_query_request_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_port = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_mac  = 48'h0000_0000_1000 + 48'(i);
         #1;
         n_checks++;
         if (bus.s_req_ready !== exp_port) begin
            n_errors++;
            $display("FAIL rr_accept_%0d: got %b required %b", i, bus.s_req_ready, exp_port);
         end
         @(negedge clk);
         n_checks++;
         if (bus.m_query_request_ip !== ((i % 2 == 0) ? 32'h0A000001 : 32'h0B000002)) begin
            n_errors++;
            $display("FAIL rr_ip_%0d: got %h", i, bus.m_query_request_ip);
         end
         bus.m_query_response_valid = 1'b1;
         bus.m_query_response_mac   = exp_mac;
         @(negedge clk);
         bus.m_query_response_valid = 1'b0;
         n_checks++;
         if (bus.s_resp_valid !== exp_port || bus.s_resp_mac !== exp_mac) begin
            n_errors++;
            $display("FAIL rr_resp_%0d: got valid=%b mac=%h required %b/%h",
                     i, bus.s_resp_valid, bus.s_resp_mac, exp_port, exp_mac);
         end
         bus.s_resp_ready = 2'b11;
         @(negedge clk);
         bus.s_resp_ready = 2'b00;
      end
      bus.s_req_valid = 2'b00;
   endtask

   task automatic test_timeout();
      int cycles;
      bus.s_req_valid = 2'b10;
      #1;
      n_checks++;
      if (bus.s_req_ready !== 2'b10) begin
         n_errors++;
         $display("FAIL timeout_accept: got %b required 10", bus.s_req_ready);
      end
      @(negedge clk);
      bus.s_req_valid            = 2'b00;
      bus.m_query_request_ready  = 1'b1;
      bus.m_query_response_valid = 1'b0;
      cycles = 1;
      while (bus.s_resp_valid === 2'b00 && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      // 15 QUERY cycles, response visible on the sixteenth sample.
      n_checks++;
      if (cycles !== 16) begin
         n_errors++;
         $display("FAIL timeout_latency: got %0d samples required 16", cycles);
      end
      n_checks++;
      if (bus.s_resp_valid !== 2'b10 || bus.s_resp_error !== 1'b1 || bus.s_resp_mac !== 48'd0) begin
         n_errors++;
         $display("FAIL timeout_resp: got valid=%b err=%b mac=%h required 10/1/0",
                  bus.s_resp_valid, bus.s_resp_error, bus.s_resp_mac);
      end
      bus.s_resp_ready = 2'b10;
      @(negedge clk);
      bus.s_resp_ready = 2'b00;
   endtask

   task automatic test_coincide();
      bus.s_req_valid = 2'b01;
      @(negedge clk);
      bus.s_req_valid           = 2'b00;
      bus.m_query_request_ready = 1'b1;
      repeat (14) @(negedge clk);
      n_checks++;
      if (bus.s_resp_valid !== 2'b00) begin
         n_errors++;
         $display("FAIL coincide_early: got %b required 00", bus.s_resp_valid);
      end
      bus.m_query_response_valid = 1'b1;
      bus.m_query_response_error = 1'b0;
      bus.m_query_response_mac   = 48'h0AAA_BBBB_CCCC;
      @(negedge clk);
      bus.m_query_response_valid = 1'b0;
      n_checks++;
      if (bus.s_resp_valid !== 2'b01 || bus.s_resp_mac !== 48'h0AAA_BBBB_CCCC || bus.s_resp_error !== 1'b0) begin
         n_errors++;
         $display("FAIL coincide_resp: got valid=%b mac=%h err=%b required 01/0aaabbbbcccc/0",
                  bus.s_resp_valid, bus.s_resp_mac, bus.s_resp_error);
      end
      bus.s_resp_ready = 2'b01;
      @(negedge clk);
      bus.s_resp_ready = 2'b00;
   endtask

   task automatic test_resp_hold();
      apply_reset();
      bus.s_req_valid = 2'b10;
      @(negedge clk);
      bus.m_query_request_ready  = 1'b1;
      bus.m_query_response_valid = 1'b1;
      bus.m_query_response_error = 1'b1;
      bus.m_query_response_mac   = 48'h0CCC_0000_0077;
      @(negedge clk);
      bus.m_query_response_valid = 1'b0;
      bus.m_query_response_mac   = 48'h1111_2222_3333;
      bus.s_req_valid            = 2'b11;
      bus.s_resp_ready           = 2'b01;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_checks++;
         if (bus.s_resp_valid !== 2'b10 || bus.s_resp_error !== 1'b1 || bus.s_resp_mac !== 48'h0CCC_0000_0077) begin
            n_errors++;
            $display("FAIL hold_stable_%0d: got valid=%b err=%b mac=%h required 10/1/0ccc00000077",
                     i, bus.s_resp_valid, bus.s_resp_error, bus.s_resp_mac);
         end
         n_checks++;
         if (bus.s_req_ready !== 2'b00 || bus.m_query_request_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_blocked_%0d: got ready=%b qvalid=%b required 00/0",
                     i, bus.s_req_ready, bus.m_query_request_valid);
         end
         @(negedge clk);
      end
      bus.s_resp_ready = 2'b10;
      @(negedge clk);
      bus.s_resp_ready = 2'b00;
      #1;
      n_checks++;
      if (bus.s_resp_valid !== 2'b00 || bus.s_req_ready !== 2'b01) begin
         n_errors++;
         $display("FAIL hold_release: got valid=%b ready=%b required 00/01", bus.s_resp_valid, bus.s_req_ready);
      end
      bus.s_req_valid = 2'b00;
   endtask

   task automatic test_reset_midquery();
      apply_reset();
      bus.s_req_valid = 2'b01;
      @(negedge clk);
      bus.s_req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (bus.s_resp_valid !== 2'b00 || bus.m_query_request_valid !== 1'b0 || bus.m_query_request_ip !== 32'd0 ||
          bus.s_resp_error !== 1'b0 || bus.s_resp_mac !== 48'd0 || bus.m_query_response_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL midquery_reset: got valid=%b qvalid=%b ip=%h err=%b mac=%h required zeros",
                  bus.s_resp_valid, bus.m_query_request_valid, bus.m_query_request_ip,
                  bus.s_resp_error, bus.s_resp_mac);
      end
      bus.s_req_valid = 2'b10;
      #1;
      n_checks++;
      if (bus.s_req_ready !== 2'b10) begin
         n_errors++;
         $display("FAIL midquery_accept: got %b required 10", bus.s_req_ready);
      end
      @(negedge clk);
      bus.s_req_valid            = 2'b00;
      bus.m_query_request_ready  = 1'b1;
      bus.m_query_response_valid = 1'b1;
      bus.m_query_response_error = 1'b0;
      bus.m_query_response_mac   = 48'h0200_0000_0002;
      n_checks++;
      if (bus.m_query_request_ip !== 32'h0B000002) begin
         n_errors++;
         $display("FAIL midquery_ip: got %h required 0b000002", bus.m_query_request_ip);
      end
      @(negedge clk);
      bus.m_query_response_valid = 1'b0;
      n_checks++;
      if (bus.s_resp_valid !== 2'b10 || bus.s_resp_mac !== 48'h0200_0000_0002) begin
         n_errors++;
         $display("FAIL midquery_resp: got valid=%b mac=%h required 10/020000000002",
                  bus.s_resp_valid, bus.s_resp_mac);
      end
      bus.s_resp_ready = 2'b10;
      @(negedge clk);
      bus.s_resp_ready = 2'b00;
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_query();
      test_round_robin();
      test_timeout();
      test_coincide();
      test_resp_hold();
      test_reset_midquery();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
      $fatal(1);
   end
endmodule
